// File: rtl/nonce_search_engine_if.sv
// Core-array and result-channel signals of the nonce search engine.
// The master modport is the engine side; the slave side is the cores plus the host.
interface nonce_search_engine_if #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned NONCE_W = 32,
  parameter int unsigned HASH_W  = 256
);
  logic                      core_issue;
  logic [LANES*NONCE_W-1:0]  core_nonce;
  logic                      core_ret_valid;
  logic [LANES*HASH_W-1:0]   core_hash;
  logic                      res_valid;
  logic                      res_ready;
  logic [NONCE_W-1:0]        res_nonce;
  logic [HASH_W-1:0]         res_hash;

  modport master (
    output core_issue, core_nonce, res_valid, res_nonce, res_hash,
    input  core_ret_valid, core_hash, res_ready
  );

  modport slave (
    input  core_issue, core_nonce, res_valid, res_nonce, res_hash,
    output core_ret_valid, core_hash, res_ready
  );
endinterface

// File: rtl/nonce_search_engine.sv
// Nonce-search controller: issues lockstep batches to LANES hash cores, tracks them in a
// tag FIFO and reports leading-zero difficulty hits over a valid/ready result channel.
module nonce_search_engine #(
  parameter int unsigned LANES    = 4,
  parameter int unsigned NONCE_W  = 32,
  parameter int unsigned HASH_W   = 256,
  parameter int unsigned DIFF_W   = 8,
  parameter int unsigned INFLIGHT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NONCE_W-1:0]   cfg_first,
  input  logic [NONCE_W-1:0]   cfg_last,
  input  logic [DIFF_W-1:0]    cfg_difficulty,
  input  logic                 cfg_continue,
  nonce_search_engine_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 exhausted,
  output logic [47:0]          hash_count,
  output logic [15:0]          dropped_hits,
  output logic                 proto_err
);
  localparam int unsigned PTR_W = $clog2(INFLIGHT);
  localparam int unsigned CNT_W = $clog2(LANES + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;

  logic [NONCE_W:0]         base, last_r;
  logic [DIFF_W-1:0]        diff_r;
  logic                     cont_r, stopped;
  logic [NONCE_W-1:0]       fifo_base [INFLIGHT];
  logic [LANES-1:0]         fifo_mask [INFLIGHT];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [PTR_W:0]           count;

  logic                     full, pop, abort_act, take_hit, stop_hit, issue_now, final_batch;
  logic [LANES-1:0]         hit, head_mask, issue_mask;
  logic [NONCE_W-1:0]       head_base, win_nonce;
  logic [HASH_W-1:0]        top_mask, win_hash;
  logic [CNT_W-1:0]         head_active;
  logic [LANES*NONCE_W-1:0] next_nonce;

  always_comb begin
    full        = count == (PTR_W+1)'(INFLIGHT);
    pop         = bus.core_ret_valid && (count != '0);
    head_base   = fifo_base[rd_ptr];
    head_mask   = fifo_mask[rd_ptr];
    // Shifting by >= HASH_W yields all-zero, so oversized difficulties clamp naturally.
    top_mask    = ~({HASH_W{1'b1}} >> diff_r);
    hit         = '0;
    head_active = '0;
    win_nonce   = '0;
    win_hash    = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      hit[i]      = head_mask[i] && ((bus.core_hash[i*HASH_W +: HASH_W] & top_mask) == '0);
      head_active = head_active + CNT_W'(head_mask[i]);
    end
    for (int unsigned i = LANES; i > 0; i--) begin
      if (hit[i-1]) begin
        win_nonce = head_base + NONCE_W'(i - 1);
        win_hash  = bus.core_hash[(i-1)*HASH_W +: HASH_W];
      end
    end
    abort_act   = abort && (state != IDLE);
    take_hit    = pop && (|hit) && !stopped && !abort_act;
    stop_hit    = take_hit && !cont_r;
    issue_now   = (state == RUN) && !full && !abort && !stop_hit;
    final_batch = (base + (NONCE_W+1)'(LANES - 1)) >= last_r;
    issue_mask  = '0;
    next_nonce  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      issue_mask[i] = (base + (NONCE_W+1)'(i)) <= last_r;
      next_nonce[i*NONCE_W +: NONCE_W] = base[NONCE_W-1:0] + NONCE_W'(i);
    end
  end

  // Tag storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (issue_now) begin
      fifo_base[wr_ptr] <= base[NONCE_W-1:0];
      fifo_mask[wr_ptr] <= issue_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      base           <= '0;
      last_r         <= '0;
      diff_r         <= '0;
      cont_r         <= 1'b0;
      stopped        <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      bus.core_issue <= 1'b0;
      bus.core_nonce <= '0;
      bus.res_valid  <= 1'b0;
      bus.res_nonce  <= '0;
      bus.res_hash   <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      exhausted      <= 1'b0;
      hash_count     <= '0;
      dropped_hits   <= '0;
      proto_err      <= 1'b0;
    end else begin
      done           <= 1'b0;
      bus.core_issue <= issue_now;
      if (issue_now) begin
        bus.core_nonce <= next_nonce;
        wr_ptr         <= wr_ptr + 1'b1;
        base           <= base + (NONCE_W+1)'(LANES);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        hash_count <= hash_count + 48'(head_active);
      end else if (bus.core_ret_valid) begin
        proto_err <= 1'b1;
      end
      count <= count + (PTR_W+1)'(issue_now) - (PTR_W+1)'(pop);

      if (abort_act) begin
        bus.res_valid <= 1'b0;
      end else if (take_hit && (!bus.res_valid || bus.res_ready)) begin
        bus.res_valid <= 1'b1;
        bus.res_nonce <= win_nonce;
        bus.res_hash  <= win_hash;
      end else begin
        if (take_hit && (dropped_hits != '1)) dropped_hits <= dropped_hits + 16'd1;
        if (bus.res_valid && bus.res_ready) bus.res_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            base         <= {1'b0, cfg_first};
            last_r       <= {1'b0, cfg_last};
            diff_r       <= cfg_difficulty;
            cont_r       <= cfg_continue;
            stopped      <= 1'b0;
            busy         <= 1'b1;
            exhausted    <= 1'b0;
            hash_count   <= '0;
            dropped_hits <= '0;
            proto_err    <= 1'b0;
            state        <= (cfg_first > cfg_last) ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (abort || stop_hit) begin
            stopped <= 1'b1;
            state   <= DRAIN;
          end else if (issue_now && final_batch) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (abort || stop_hit) stopped <= 1'b1;
          if ((count == '0) && !bus.res_valid) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            exhausted <= !(stopped || abort);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nonce_search_engine.sv
// Bench for nonce_search_engine: a latency-configurable core responder and a result
// collector, checked against a nonce-range/leading-zero reference model.
module tb_nonce_search_engine;
  localparam int unsigned LANES = 4;
  localparam int unsigned NW    = 32;
  localparam int unsigned HW    = 256;
  localparam int unsigned DW    = 8;
  localparam int unsigned INF   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NW-1:0] cfg_first = '0;
  logic [NW-1:0] cfg_last = '0;
  logic [DW-1:0] cfg_difficulty = '0;
  logic          cfg_continue = 1'b0;
  logic          busy, done, exhausted, proto_err;
  logic [47:0]   hash_count;
  logic [15:0]   dropped_hits;

  nonce_search_engine_if #(.LANES(LANES), .NONCE_W(NW), .HASH_W(HW)) bus ();

  nonce_search_engine #(
    .LANES(LANES), .NONCE_W(NW), .HASH_W(HW), .DIFF_W(DW), .INFLIGHT(INF)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_first(cfg_first), .cfg_last(cfg_last), .cfg_difficulty(cfg_difficulty),
    .cfg_continue(cfg_continue), .bus(bus),
    .busy(busy), .done(done), .exhausted(exhausted), .hash_count(hash_count),
    .dropped_hits(dropped_hits), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  int lz_map [bit [NW-1:0]];
  int unsigned lat = 3;
  bit core_hold = 1'b0;
  bit inject_ret = 1'b0;
  logic [LANES*NW-1:0] pend_q [$];
  int unsigned pend_t [$];
  int unsigned cyc = 0, outstanding = 0, max_out = 0, issued = 0, returned = 0;
  logic [NW-1:0] issue_log [$];
  logic [NW-1:0] got_n [$];
  logic [HW-1:0] got_h [$];
  logic [NW-1:0] exp_n [$];

  task automatic check(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int lz_of(input logic [NW-1:0] n);
    return lz_map.exists(n) ? lz_map[n] : 0;
  endfunction

  // Deterministic per-nonce hash with exactly lz_of(n) leading zero bits.
  function automatic logic [HW-1:0] hash_of(input logic [NW-1:0] n);
    logic [HW-1:0] h;
    int lz;
    for (int k = 0; k < 8; k++) h[k*32 +: 32] = n * 32'h9E3779B1 + 32'(k) * 32'h7F4A7C15 + 32'h01234567;
    h[HW-1] = 1'b1;
    lz = lz_of(n);
    return (lz >= int'(HW)) ? '0 : (h >> lz);
  endfunction

  // Expected reports with every hit accepted: per batch of LANES, the lowest in-range hit.
  task automatic build_expect(input longint first, input longint last, input int d);
    exp_n.delete();
    for (longint b = first; b <= last; b += LANES) begin
      for (longint n = b; (n < b + LANES) && (n <= last); n++) begin
        if (lz_of(NW'(n)) >= d) begin
          exp_n.push_back(NW'(n));
          break;
        end
      end
    end
  endtask

  task automatic compare_results(input string tag);
    check({tag, " hit count"}, HW'(got_n.size()), HW'(exp_n.size()));
    for (int i = 0; (i < exp_n.size()) && (i < got_n.size()); i++) begin
      check($sformatf("%s nonce[%0d]", tag, i), HW'(got_n[i]), HW'(exp_n[i]));
      check($sformatf("%s hash[%0d]", tag, i), got_h[i], hash_of(exp_n[i]));
    end
  endtask

  task automatic run_start(input logic [NW-1:0] first, input logic [NW-1:0] last,
                           input logic [DW-1:0] d, input logic cont);
    @(negedge clk);
    got_n.delete(); got_h.delete(); issue_log.delete();
    issued = 0; returned = 0; max_out = 0;
    cfg_first = first; cfg_last = last; cfg_difficulty = d; cfg_continue = cont;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble config: it must only be sampled with start.
    cfg_first = $urandom; cfg_last = $urandom; cfg_difficulty = DW'($urandom); cfg_continue = ~cont;
  endtask

  task automatic wait_done(input int unsigned budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int unsigned c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, " done"}, HW'(seen), HW'(1));
  endtask

  // Core array model: returns batches in issue order, at most one per cycle, after lat cycles.
  initial begin
    bus.core_ret_valid = 1'b0;
    bus.core_hash = '0;
    forever begin : responder
      logic [LANES*NW-1:0] nv;
      @(negedge clk);
      #1;
      cyc++;
      if (bus.core_issue === 1'b1) begin
        pend_q.push_back(bus.core_nonce);
        pend_t.push_back(cyc);
        issue_log.push_back(bus.core_nonce[NW-1:0]);
        issued++;
        outstanding++;
        if (outstanding > max_out) max_out = outstanding;
      end
      bus.core_ret_valid = 1'b0;
      if (inject_ret) begin
        bus.core_ret_valid = 1'b1;
        bus.core_hash = '1;
      end else if (!core_hold && (pend_q.size() != 0) && (cyc - pend_t[0] >= lat)) begin
        nv = pend_q.pop_front();
        void'(pend_t.pop_front());
        for (int i = 0; i < LANES; i++) bus.core_hash[i*HW +: HW] = hash_of(nv[i*NW +: NW]);
        bus.core_ret_valid = 1'b1;
        outstanding--;
        returned++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if ((bus.res_valid === 1'b1) && (bus.res_ready === 1'b1)) begin
        got_n.push_back(bus.res_nonce);
        got_h.push_back(bus.res_hash);
      end
    end
  end

  initial begin
    longint rf, rl;
    int rd;
    bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst busy", HW'(busy), HW'(0));
    check("rst done", HW'(done), HW'(0));
    check("rst core_issue", HW'(bus.core_issue), HW'(0));
    check("rst res_valid", HW'(bus.res_valid), HW'(0));
    check("rst hash_count", HW'(hash_count), HW'(0));
    check("rst dropped", HW'(dropped_hits), HW'(0));
    check("rst proto_err", HW'(proto_err), HW'(0));
    check("rst exhausted", HW'(exhausted), HW'(0));
    rst = 1'b0;

    // Stop at first hit: difficulty 0 makes lane 0 of the first batch win.
    lz_map.delete(); lat = 3;
    run_start(32'd0, 32'd7, 8'd0, 1'b0);
    wait_done(200, "first_hit");
    check("first_hit count", HW'(got_n.size()), HW'(1));
    if (got_n.size() > 0) begin
      check("first_hit nonce", HW'(got_n[0]), HW'(0));
      check("first_hit hash", got_h[0], hash_of(32'd0));
    end
    check("first_hit exhausted", HW'(exhausted), HW'(0));
    check("first_hit busy", HW'(busy), HW'(0));

    // Partial last batch: lanes 10,11 masked (nonce 10 would hit if checked).
    lz_map.delete(); lz_map[10] = 256; lz_map[3] = 254;
    run_start(32'd0, 32'd9, 8'd255, 1'b0);
    wait_done(200, "masked");
    check("masked batches", HW'(issued), HW'(3));
    for (int i = 0; (i < 3) && (i < issue_log.size()); i++)
      check($sformatf("masked base[%0d]", i), HW'(issue_log[i]), HW'(4 * i));
    check("masked hits", HW'(got_n.size()), HW'(0));
    check("masked hash_count", HW'(hash_count), HW'(10));
    check("masked exhausted", HW'(exhausted), HW'(1));

    // Top of nonce space: one batch, no wrap to 0.
    lz_map.delete();
    run_start(32'hFFFF_FFFE, 32'hFFFF_FFFF, 8'd0, 1'b1);
    wait_done(200, "top");
    repeat (5) @(negedge clk);
    check("top batches", HW'(issued), HW'(1));
    if (issue_log.size() > 0) check("top base", HW'(issue_log[0]), HW'(32'hFFFF_FFFE));
    exp_n.delete(); exp_n.push_back(32'hFFFF_FFFE);
    compare_results("top");
    check("top hash_count", HW'(hash_count), HW'(2));
    check("top exhausted", HW'(exhausted), HW'(1));

    // Latency beyond FIFO depth: issue stalls at INF outstanding.
    lz_map.delete(); lat = 40;
    for (int n = 0; n < 120; n++)
      lz_map[NW'(n)] = ($urandom_range(0, 15) == 0) ? int'($urandom_range(200, 256)) : int'($urandom_range(0, 199));
    build_expect(0, 119, 200);
    run_start(32'd0, 32'd119, 8'd200, 1'b1);
    wait_done(3000, "deep");
    check("deep max outstanding", HW'(max_out), HW'(INF));
    check("deep batches", HW'(issued), HW'(30));
    check("deep returned", HW'(returned), HW'(30));
    compare_results("deep");
    check("deep hash_count", HW'(hash_count), HW'(120));
    check("deep dropped", HW'(dropped_hits), HW'(0));
    check("deep exhausted", HW'(exhausted), HW'(1));

    // Held result: nonce 5 stays, hit on 9 dropped.
    lz_map.delete(); lz_map[5] = 20; lz_map[9] = 20; lat = 2;
    bus.res_ready = 1'b0;
    run_start(32'd0, 32'd15, 8'd16, 1'b1);
    for (int c = 0; (c < 300) && (returned < 4); c++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("hold returned", HW'(returned), HW'(4));
    check("hold res_valid", HW'(bus.res_valid), HW'(1));
    check("hold res_nonce", HW'(bus.res_nonce), HW'(5));
    check("hold res_hash", bus.res_hash, hash_of(32'd5));
    check("hold dropped", HW'(dropped_hits), HW'(1));
    check("hold busy", HW'(busy), HW'(1));
    bus.res_ready = 1'b1;
    wait_done(100, "hold");
    exp_n.delete(); exp_n.push_back(32'd5);
    compare_results("hold");
    check("hold exhausted", HW'(exhausted), HW'(1));

    // Abort with 6 batches in flight.
    lz_map.delete(); lat = 1; core_hold = 1'b1;
    run_start(32'd0, 32'd1023, 8'd0, 1'b1);
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (5) @(negedge clk);
    check("abort issued", HW'(issued), HW'(6));
    check("abort core_issue", HW'(bus.core_issue), HW'(0));
    check("abort res_valid", HW'(bus.res_valid), HW'(0));
    check("abort busy", HW'(busy), HW'(1));
    core_hold = 1'b0;
    wait_done(100, "abort");
    check("abort returned at done", HW'(returned), HW'(6));
    check("abort hits", HW'(got_n.size()), HW'(0));
    check("abort exhausted", HW'(exhausted), HW'(0));

    // Randomised ranges against the reference model.
    for (int it = 0; it < 4; it++) begin
      lz_map.delete();
      rf = (it == 3) ? longint'(32'hFFFF_FFFF) - longint'($urandom_range(0, 10)) : longint'($urandom);
      rl = rf + longint'($urandom_range(0, 40));
      if (rl > longint'(32'hFFFF_FFFF)) rl = longint'(32'hFFFF_FFFF);
      rd = int'($urandom_range(0, 6));
      for (longint n = rf; n <= rl; n++) lz_map[NW'(n)] = int'($urandom_range(0, 8));
      lat = $urandom_range(1, 20);
      build_expect(rf, rl, rd);
      run_start(NW'(rf), NW'(rl), DW'(rd), 1'b1);
      wait_done(2000, $sformatf("rand%0d", it));
      compare_results($sformatf("rand%0d", it));
      check($sformatf("rand%0d hash_count", it), HW'(hash_count), HW'(rl - rf + 1));
      check($sformatf("rand%0d dropped", it), HW'(dropped_hits), HW'(0));
      check($sformatf("rand%0d exhausted", it), HW'(exhausted), HW'(1));
    end

    // Reset mid-search: late returns hit an empty tag FIFO.
    lz_map.delete(); lat = 1; core_hold = 1'b1;
    run_start(32'd0, 32'd1023, 8'd0, 1'b1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", HW'(busy), HW'(0));
    core_hold = 1'b0;
    for (int c = 0; (c < 100) && (pend_q.size() != 0); c++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("midrst proto_err", HW'(proto_err), HW'(1));
    check("midrst res_valid", HW'(bus.res_valid), HW'(0));
    check("midrst core_issue", HW'(bus.core_issue), HW'(0));

    // Stray return in IDLE, then an empty range clears it and finishes in 2 cycles.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    inject_ret = 1'b1;
    @(negedge clk);
    inject_ret = 1'b0;
    @(negedge clk);
    check("idle proto_err", HW'(proto_err), HW'(1));
    cfg_first = 32'd10; cfg_last = 32'd5; cfg_difficulty = 8'd0; cfg_continue = 1'b0;
    issued = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("empty busy", HW'(busy), HW'(1));
    check("empty early done", HW'(done), HW'(0));
    check("empty proto_err clr", HW'(proto_err), HW'(0));
    @(negedge clk);
    check("empty done", HW'(done), HW'(1));
    check("empty exhausted", HW'(exhausted), HW'(1));
    check("empty idle", HW'(busy), HW'(0));
    @(negedge clk);
    check("empty done pulse", HW'(done), HW'(0));
    check("empty exhausted sticky", HW'(exhausted), HW'(1));
    check("empty no issue", HW'(issued), HW'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
